// File: rtl/rect_pkg.sv
// Shared definitions for the rectangle filler: screen geometry,
// FSM state encoding and the blank colour value.
package rect_pkg;

    localparam int SCREEN_W     = 160;
    localparam int SCREEN_H     = 120;
    localparam int COLOUR_BLACK = 0;

    typedef enum logic {
        IDLE = 1'b0,
        DRAW = 1'b1
    } state_t;

endpackage

// File: rtl/rect_scan_counter.sv
// Nested column/row scan counter for the rectangle filler.
// Ports: clock, reset (async high), clear (zero both counters),
//   advance (step one pixel), width/height (extent), col/row (position),
//   last (currently on the final pixel of the rectangle).
module rect_scan_counter #(
    parameter int DIM_W = 5
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             advance,
    input  logic [DIM_W-1:0] width,
    input  logic [DIM_W-1:0] height,
    output logic [DIM_W-1:0] col,
    output logic [DIM_W-1:0] row,
    output logic             last
);

    logic col_end;

    assign col_end = (col == width - DIM_W'(1));
    assign last    = col_end && (row == height - DIM_W'(1));

    // Holding is implicit: without advance the counters keep their value.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            col <= '0;
            row <= '0;
        end else if (clear) begin
            col <= '0;
            row <= '0;
        end else if (advance) begin
            if (col_end) begin
                col <= '0;
                row <= row + DIM_W'(1);
            end else begin
                col <= col + DIM_W'(1);
            end
        end
    end

endmodule

// File: rtl/rect_filler.sv
// Rectangle filler: streams one pixel per cycle of a solid rectangle.
// Ports: clock, reset (async high), start + refX/refY/rectW/rectH/
//   fillColour/dirUp request, stall backpressure; x/y/colour/writeEn
//   pixel stream, done/busy status. Define RECT_FILLER_CLIP_EN to drop
//   writes that fall outside the SCREEN_W x SCREEN_H screen.
module rect_filler
    import rect_pkg::*;
#(
    parameter int X_W      = 8,
    parameter int Y_W      = 7,
    parameter int DIM_W    = 5,
    parameter int COLOUR_W = 3
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
    input  logic [X_W-1:0]      refX,
    input  logic [Y_W-1:0]      refY,
    input  logic [DIM_W-1:0]    rectW,
    input  logic [DIM_W-1:0]    rectH,
    input  logic [COLOUR_W-1:0] fillColour,
    input  logic                dirUp,
    input  logic                stall,
    output logic [X_W-1:0]      x,
    output logic [Y_W-1:0]      y,
    output logic [COLOUR_W-1:0] colour,
    output logic                writeEn,
    output logic                done,
    output logic                busy
);

    state_t state, state_nx;

    logic [X_W-1:0]      ref_x;
    logic [Y_W-1:0]      ref_y;
    logic [DIM_W-1:0]    rect_w;
    logic [DIM_W-1:0]    rect_h;
    logic [COLOUR_W-1:0] fill_c;
    logic                dir_up;

    logic [DIM_W-1:0] col;
    logic [DIM_W-1:0] row;
    logic             last;
    logic             zero_dim;
    logic             advance;
    logic             in_screen;

    assign zero_dim = (rect_w == '0) || (rect_h == '0);

    // A start cycle emits nothing, so it must not step the counters.
    assign advance = (state == DRAW) && !start && !stall && !zero_dim;

    rect_scan_counter #(
        .DIM_W (DIM_W)
    ) u_scan (
        .clock   (clock),
        .reset   (reset),
        .clear   (start),
        .advance (advance),
        .width   (rect_w),
        .height  (rect_h),
        .col     (col),
        .row     (row),
        .last    (last)
    );

`ifdef RECT_FILLER_CLIP_EN
    logic signed [31:0] ux;
    logic signed [31:0] uy;

    // Unwrapped coordinates, so pixels past an edge are not folded back.
    always_comb begin
        ux = 32'(ref_x) + 32'(col);
        if (dir_up) begin
            uy = 32'(ref_y) - 32'(row);
        end else begin
            uy = 32'(ref_y) + 32'(row);
        end
        in_screen = (ux < SCREEN_W) && (uy >= 0) && (uy < SCREEN_H);
    end
`else
    assign in_screen = 1'b1;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            ref_x  <= '0;
            ref_y  <= '0;
            rect_w <= '0;
            rect_h <= '0;
            fill_c <= '0;
            dir_up <= 1'b0;
        end else begin
            state <= state_nx;
            if (start) begin
                ref_x  <= refX;
                ref_y  <= refY;
                rect_w <= rectW;
                rect_h <= rectH;
                fill_c <= fillColour;
                dir_up <= dirUp;
            end
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nx = DRAW;
                end
            end
            DRAW: begin
                if (start) begin
                    state_nx = DRAW;
                end else if (zero_dim) begin
                    state_nx = IDLE;
                end else if (!stall && last) begin
                    state_nx = IDLE;
                end
            end
        endcase
    end

    always_comb begin
        x       = '0;
        y       = '0;
        colour  = COLOUR_W'(COLOUR_BLACK);
        writeEn = 1'b0;
        done    = 1'b1;
        busy    = 1'b0;
        if (state == DRAW) begin
            done   = 1'b0;
            busy   = 1'b1;
            x      = ref_x + X_W'(col);
            colour = fill_c;
            if (dir_up) begin
                y = ref_y - Y_W'(row);
            end else begin
                y = ref_y + Y_W'(row);
            end
            writeEn = !start && !stall && !zero_dim && in_screen;
        end
    end

endmodule

// File: tb/tb_rect_filler.sv
// Self-checking bench for rect_filler: directed scenarios plus
// randomized fills compared against a pixel-list reference model.
module tb_rect_filler;

    localparam int X_W      = 8;
    localparam int Y_W      = 7;
    localparam int DIM_W    = 5;
    localparam int COLOUR_W = 3;

    logic                clock = 1'b0;
    logic                reset = 1'b1;
    logic                start = 1'b0;
    logic [X_W-1:0]      refX = '0;
    logic [Y_W-1:0]      refY = '0;
    logic [DIM_W-1:0]    rectW = '0;
    logic [DIM_W-1:0]    rectH = '0;
    logic [COLOUR_W-1:0] fillColour = '0;
    logic                dirUp = 1'b0;
    logic                stall = 1'b0;
    logic [X_W-1:0]      x;
    logic [Y_W-1:0]      y;
    logic [COLOUR_W-1:0] colour;
    logic                writeEn;
    logic                done;
    logic                busy;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        int x;
        int y;
        int c;
    } pix_t;

    pix_t expq[$];

    rect_filler #(
        .X_W      (X_W),
        .Y_W      (Y_W),
        .DIM_W    (DIM_W),
        .COLOUR_W (COLOUR_W)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .refX       (refX),
        .refY       (refY),
        .rectW      (rectW),
        .rectH      (rectH),
        .fillColour (fillColour),
        .dirUp      (dirUp),
        .stall      (stall),
        .x          (x),
        .y          (y),
        .colour     (colour),
        .writeEn    (writeEn),
        .done       (done),
        .busy       (busy)
    );

    always #5 clock = ~clock;

    // Reference: list of written pixels in raster order.
    task automatic build_model(input int rx, input int ry, input int w,
                               input int h, input int c, input int up);
        pix_t p;
        int   ux;
        int   uy;
        expq.delete();
        for (int r = 0; r < h; r++) begin
            for (int k = 0; k < w; k++) begin
                ux = rx + k;
                uy = (up != 0) ? ry - r : ry + r;
`ifdef RECT_FILLER_CLIP_EN
                if (ux >= 160 || uy < 0 || uy >= 120) continue;
`endif
                p.x = ux % 256;
                p.y = ((uy % 128) + 128) % 128;
                p.c = c;
                expq.push_back(p);
            end
        end
    endtask

    task automatic set_req(input int rx, input int ry, input int w,
                           input int h, input int c, input int up);
        refX       = X_W'(rx);
        refY       = Y_W'(ry);
        rectW      = DIM_W'(w);
        rectH      = DIM_W'(h);
        fillColour = COLOUR_W'(c);
        dirUp      = (up != 0);
    endtask

    // Drive inputs for the next rising edge, then sample settled outputs.
    task automatic tick(input logic s, input logic st);
        @(negedge clock);
        start = s;
        stall = st;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #3;
        vectors++;
        if ({writeEn, done, busy, x, y, colour} !== {3'b010, 18'd0}) begin
            miscompares++;
            $display("FAIL reset_state got we=%b done=%b busy=%b x=%0d y=%0d c=%0d",
                     writeEn, done, busy, x, y, colour);
        end
        @(negedge clock);
        reset = 1'b0;
        tick(1'b0, 1'b1);
        tick(1'b0, 1'b1);
        vectors++;
        if (writeEn !== 1'b0 || done !== 1'b1 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL idle_stall got we=%b done=%b busy=%b want 0 1 0",
                     writeEn, done, busy);
        end
    endtask

    task automatic test_basic();
        pix_t e;
        set_req(10, 20, 8, 8, 0, 1);
        build_model(10, 20, 8, 8, 0, 1);
        tick(1'b1, 1'b0);
        for (int i = 0; i < 64; i++) begin
            tick(1'b0, 1'b0);
            e = expq.pop_front();
            vectors++;
            if (writeEn !== 1'b1 || x !== X_W'(e.x) || y !== Y_W'(e.y)
                || colour !== COLOUR_W'(e.c)) begin
                miscompares++;
                $display("FAIL basic_px%0d got we=%b (%0d,%0d) c=%0d want (%0d,%0d) c=%0d",
                         i, writeEn, x, y, colour, e.x, e.y, e.c);
            end
            if (i == 0 || i == 63) begin
                vectors++;
                if ((i == 0 && (x !== 8'd10 || y !== 7'd20))
                    || (i == 63 && (x !== 8'd17 || y !== 7'd13))) begin
                    miscompares++;
                    $display("FAIL basic_corner%0d got (%0d,%0d)", i, x, y);
                end
            end
        end
        tick(1'b0, 1'b0);
        vectors++;
        if (done !== 1'b1 || writeEn !== 1'b0 || {x, y, colour} !== 18'd0) begin
            miscompares++;
            $display("FAIL basic_end got done=%b we=%b x=%0d y=%0d c=%0d want 1 0 0 0 0",
                     done, writeEn, x, y, colour);
        end
    endtask

    task automatic test_zero();
        set_req(7, 7, 0, 5, 3, 0);
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        vectors++;
        if (writeEn !== 1'b0) begin
            miscompares++;
            $display("FAIL zero_we got %b want 0", writeEn);
        end
        tick(1'b0, 1'b0);
        vectors++;
        if (done !== 1'b1 || writeEn !== 1'b0) begin
            miscompares++;
            $display("FAIL zero_done got done=%b we=%b want 1 0", done, writeEn);
        end
    endtask

    task automatic test_stall();
        pix_t e;
        int   writes = 0;
        bit   fin = 0;
        logic st;
        set_req(30, 40, 3, 2, 5, 0);
        build_model(30, 40, 3, 2, 5, 0);
        tick(1'b1, 1'b0);
        for (int k = 1; k <= 30; k++) begin
            st = (k >= 2 && k <= 4);
            tick(1'b0, st);
            if (done === 1'b1) begin
                fin = 1;
                break;
            end
            vectors++;
            if (st) begin
                e = expq[0];
                if (writeEn !== 1'b0 || x !== X_W'(e.x) || y !== Y_W'(e.y)) begin
                    miscompares++;
                    $display("FAIL stall_hold cyc%0d got we=%b (%0d,%0d) want 0 (%0d,%0d)",
                             k, writeEn, x, y, e.x, e.y);
                end
            end else begin
                e = expq.pop_front();
                writes++;
                if (writeEn !== 1'b1 || x !== X_W'(e.x) || y !== Y_W'(e.y)
                    || colour !== COLOUR_W'(e.c)) begin
                    miscompares++;
                    $display("FAIL stall_px cyc%0d got we=%b (%0d,%0d) c=%0d want (%0d,%0d) c=%0d",
                             k, writeEn, x, y, colour, e.x, e.y, e.c);
                end
            end
        end
        vectors++;
        if (!fin || writes != 6 || expq.size() != 0) begin
            miscompares++;
            $display("FAIL stall_total got fin=%0d writes=%0d left=%0d want 1 6 0",
                     fin, writes, expq.size());
        end
    endtask

    task automatic test_restart();
        pix_t e;
        int   n = 0;
        bit   fin = 0;
        set_req(5, 5, 8, 8, 1, 0);
        tick(1'b1, 1'b0);
        repeat (10) tick(1'b0, 1'b0);
        set_req(50, 60, 4, 4, 6, 1);
        build_model(50, 60, 4, 4, 6, 1);
        tick(1'b1, 1'b0);
        vectors++;
        if (writeEn !== 1'b0) begin
            miscompares++;
            $display("FAIL restart_start_we got %b want 0", writeEn);
        end
        for (int k = 0; k < 40; k++) begin
            tick(1'b0, 1'b0);
            if (done === 1'b1) begin
                fin = 1;
                break;
            end
            vectors++;
            if (expq.size() == 0) begin
                miscompares++;
                $display("FAIL restart_extra got we=%b (%0d,%0d) want none", writeEn, x, y);
            end else begin
                e = expq.pop_front();
                if (writeEn !== 1'b1 || x !== X_W'(e.x) || y !== Y_W'(e.y)
                    || colour !== COLOUR_W'(e.c) || (n == 0 && x !== 8'd50)) begin
                    miscompares++;
                    $display("FAIL restart_px%0d got we=%b (%0d,%0d) c=%0d want (%0d,%0d) c=%0d",
                             n, writeEn, x, y, colour, e.x, e.y, e.c);
                end
            end
            n++;
        end
        vectors++;
        if (!fin || expq.size() != 0 || n != 16) begin
            miscompares++;
            $display("FAIL restart_total got fin=%0d pixels=%0d left=%0d want 1 16 0",
                     fin, n, expq.size());
        end
    endtask

    task automatic test_async_reset();
        int writes = 0;
        set_req(20, 30, 6, 6, 7, 0);
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        vectors++;
        if ({writeEn, done, busy, x, y, colour} !== {3'b010, 18'd0}) begin
            miscompares++;
            $display("FAIL async_reset got we=%b done=%b busy=%b x=%0d y=%0d c=%0d",
                     writeEn, done, busy, x, y, colour);
        end
        @(negedge clock);
        reset = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick(1'b0, 1'b0);
            if (writeEn === 1'b1) writes++;
        end
        vectors++;
        if (writes != 0 || done !== 1'b1) begin
            miscompares++;
            $display("FAIL async_after got writes=%0d done=%b want 0 1", writes, done);
        end
    endtask

`ifdef RECT_FILLER_CLIP_EN
    task automatic test_clip();
        int cyc = 0;
        int writes = 0;
        int xs[$];
        set_req(158, 10, 4, 1, 2, 0);
        tick(1'b1, 1'b0);
        for (int k = 0; k < 12; k++) begin
            tick(1'b0, 1'b0);
            if (done === 1'b1) break;
            cyc++;
            if (writeEn === 1'b1) begin
                writes++;
                xs.push_back(int'(x));
            end
        end
        vectors++;
        if (cyc != 4 || writes != 2 || xs[0] != 158 || xs[1] != 159) begin
            miscompares++;
            $display("FAIL clip got cycles=%0d writes=%0d want 4 2 at x=158,159",
                     cyc, writes);
        end
    endtask
`endif

    task automatic test_random();
        pix_t e;
        int   rx, ry, w, h, c, up, budget, pc;
        bit   fin;
        logic st;
        for (int it = 0; it < 14; it++) begin
            rx = $urandom_range(255);
            ry = $urandom_range(127);
            w  = (it == 0) ? 31 : $urandom_range(0, 12);
            h  = (it == 0) ? 3 : $urandom_range(0, 12);
            c  = $urandom_range(7);
            up = $urandom_range(1);
            set_req(rx, ry, w, h, c, up);
            build_model(rx, ry, w, h, c, up);
            budget = 4 * w * h + 40;
            pc  = 0;
            fin = 0;
            tick(1'b1, 1'($urandom_range(1)));
            for (int k = 0; k < budget; k++) begin
                st = ($urandom_range(99) < 30);
                tick(1'b0, st);
                if (done === 1'b1) begin
                    fin = 1;
                    break;
                end
                if (!st) pc++;
                if (writeEn === 1'b1) begin
                    vectors++;
                    if (st || expq.size() == 0) begin
                        miscompares++;
                        $display("FAIL rand%0d_spurious got we=1 (%0d,%0d) stall=%b left=%0d",
                                 it, x, y, st, expq.size());
                    end else begin
                        e = expq.pop_front();
                        if (x !== X_W'(e.x) || y !== Y_W'(e.y)
                            || colour !== COLOUR_W'(e.c)) begin
                            miscompares++;
                            $display("FAIL rand%0d_px got (%0d,%0d) c=%0d want (%0d,%0d) c=%0d",
                                     it, x, y, colour, e.x, e.y, e.c);
                        end
                    end
                end
            end
            vectors++;
            if (!fin || expq.size() != 0 || (w != 0 && h != 0 && pc != w * h)) begin
                miscompares++;
                $display("FAIL rand%0d_total got fin=%0d left=%0d pixcycles=%0d want 1 0 %0d",
                         it, fin, expq.size(), pc, w * h);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero();
        test_stall();
        test_restart();
        test_async_reset();
`ifdef RECT_FILLER_CLIP_EN
        test_clip();
`endif
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/rect_filler.md
RECT_FILLER -- requirements
Module: rect_filler

Interface
REQ-001 SHALL have parameter X_W, default 8, meaning x coordinate width.
REQ-002 SHALL have parameter Y_W, default 7, meaning y coordinate width.
REQ-003 SHALL have parameter DIM_W, default 5, meaning width/height field width (max extent 2^DIM_W-1).
REQ-004 SHALL have parameter COLOUR_W, default 3, meaning pixel colour width.
REQ-005 SHALL have port clock, input, 1, the single clock; all state on its rising edge.
REQ-006 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-007 SHALL have port start, input, 1, begin a fill (captures all request inputs).
REQ-008 SHALL have ports refX (input, X_W) and refY (input, Y_W), the anchor pixel.
REQ-009 SHALL have ports rectW (input, DIM_W) and rectH (input, DIM_W), the rectangle extent in pixels.
REQ-010 SHALL have port fillColour, input, COLOUR_W, the colour to write.
REQ-011 SHALL have port dirUp, input, 1: 1 = rows advance y-1 (upward from refY), 0 = rows advance y+1.
REQ-012 SHALL have port stall, input, 1, plotter backpressure; 1 = hold the current pixel.
REQ-013 SHALL have ports x (output, X_W), y (output, Y_W), colour (output, COLOUR_W), writeEn (output, 1), done (output, 1), busy (output, 1).

Function
REQ-014 SHALL implement states IDLE and DRAW; done=1 and busy=0 in IDLE; done=0 and busy=1 in DRAW.
REQ-015 SHALL, on start=1 in any state, latch refX, refY, rectW, rectH, fillColour and dirUp, clear the column/row counters, drive writeEn=0, and enter DRAW; a start during DRAW aborts the current fill and restarts.
REQ-016 SHALL, if the latched rectW or rectH is 0, return to IDLE on the cycle after start with no writeEn pulse.
REQ-017 SHALL, in DRAW with stall=0, present per cycle x=refX+col and y=refY-row (dirUp=1) or refY+row (dirUp=0), colour=latched colour, writeEn=1, then advance col; when col reaches rectW-1, col wraps to 0 and row increments.
REQ-018 SHALL present the first pixel (col 0, row 0) on the cycle after start is sampled; a full fill emits exactly rectW*rectH writeEn cycles when stall is never asserted.
REQ-019 SHALL, while stall=1 in DRAW, hold x, y, colour and counters, and drive writeEn=0.
REQ-020 SHALL, after the pixel (rectW-1, rectH-1) is emitted, enter IDLE on the next edge with writeEn=0, x=0, y=0, colour=0.
REQ-021 SHALL compute coordinate arithmetic modulo 2^X_W and 2^Y_W (wrap-around, no saturation) when CLIP_EN is absent.
REQ-022 SHALL ignore stall in IDLE and SHALL give start priority over stall.

Reset
REQ-023 SHALL, on reset=1, asynchronously force IDLE, counters 0, x=0, y=0, colour=0, writeEn=0, done=1, busy=0.
REQ-024 SHALL, when reset asserts mid-fill, abandon the fill; no pixel is emitted after reset deasserts until a new start.

Configuration
REQ-025 SHALL, with macro RECT_FILLER_CLIP_EN defined, suppress writeEn (counters still advance, one cycle per pixel) for any pixel whose unwrapped coordinate falls outside 0..SCREEN_W-1 or 0..SCREEN_H-1; without it, every pixel is written per REQ-021.

Structure
REQ-026 SHALL take SCREEN_W=160, SCREEN_H=120, the state encoding typedef and the COLOUR_BLACK=0 constant from shared package rect_pkg.
REQ-027 SHALL place the col/row nested counter with wrap and stall-hold in one sub-module, rect_scan_counter.

Verification
REQ-028 Reset then start, refX=10, refY=20, 8x8, colour=0, dirUp=1 -> 64 consecutive writeEn cycles, first (10,20), last (17,13), done=1 on the following cycle.
REQ-029 Start with rectW=0, rectH=5 -> no writeEn, done=1 one cycle after start.
REQ-030 3x2 fill, dirUp=0, colour=5, stall high for cycles 2-4 -> writeEn low while stalled, pixel held, six writes total in scan order (refX..refX+2, refY..refY+1).
REQ-031 Restart start mid-fill after 10 pixels with new refX=50 -> next pixel is (50, new refY), old fill never resumes.
REQ-032 Reset asserted asynchronously mid-fill (between clock edges) -> outputs zero immediately, done=1, no further writeEn.
REQ-033 With RECT_FILLER_CLIP_EN, refX=158, 4x1 fill -> writeEn for x=158,159 only; done after 4 pixel cycles.
